// File: rtl/data_memory_if.sv
// Request/response bus between the cache controller and the line-wide data memory.
// The controller drives the request side; the memory returns the ack strobe and read line.
interface data_memory_if;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o
    );
endinterface

// File: rtl/data_memory.sv
// Fixed-latency 256-bit line memory behind the cache controller: one request in flight,
// latched at acceptance and completed LATENCY edges later with a one-cycle ack strobe.
module data_memory #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    data_memory_if.slave bus
);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic               r_ack;
    logic [255:0]       r_rdata;
    logic [IDX_W-1:0]   r_idx;
    logic               r_write;
    logic [255:0]       r_wdata;
    logic [255:0]       r_mem [DEPTH];

    logic [IDX_W-1:0]   w_idx;
    logic               w_last;
    logic               w_mem_we;
    logic               w_unused;

    assign w_idx    = bus.addr_i[5 +: IDX_W];
    assign w_unused = &{1'b0, bus.addr_i[31:5+IDX_W], bus.addr_i[4:0]};
    assign w_last   = (r_state == ST_BUSY) && (r_cnt == 8'd1);
    // Gate with rst_i so a reset landing on the completion edge cancels the write.
    assign w_mem_we = rst_i && w_last && r_write;

    assign bus.ack_o  = r_ack;
    assign bus.data_o = r_rdata;

    // Request FSM, latency counter and registered ack/read-data outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_ack   <= 1'b0;
            r_rdata <= 256'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= 256'd0;
        end else begin
            // The strobe follows the access cycle by one register stage, so the
            // requester sees it exactly LATENCY edges after acceptance.
            r_ack <= (r_state == ST_ACK);
            case (r_state)
                ST_IDLE: begin
                    if (bus.enable_i) begin
                        r_idx   <= w_idx;
                        r_write <= bus.write_i;
                        r_wdata <= bus.data_i;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state <= ST_ACK;
                        if (!r_write) begin
                            r_rdata <= r_mem[r_idx];
                        end else begin
                            r_rdata <= r_rdata;
                        end
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Line storage; deliberately not reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end
endmodule
